// File: rtl/fa_ha_core_if.sv
// fa_ha_core_if: operand/result bundle for the registered half-adder ripple adder.
// Signals: a, b, cin (operands, driven by master); s, cout (registered results);
//          ovf (signed overflow, only when FA_HA_OVF_EN is defined).
interface fa_ha_core_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] s;
  logic             cout;
`ifdef FA_HA_OVF_EN
  logic             ovf;
`endif

  // Master supplies operands and observes results.
  modport master (
    output a, b, cin,
`ifdef FA_HA_OVF_EN
    input  ovf,
`endif
    input  s, cout
  );

  // Slave (the adder) consumes operands and produces results.
  modport slave (
    input  a, b, cin,
`ifdef FA_HA_OVF_EN
    output ovf,
`endif
    output s, cout
  );
endinterface

// File: rtl/fa_ha_core.sv
// fa_ha_core: registered ripple-carry adder, each bit a full adder of two half adders.
// Latency 1 cycle, throughput 1 per cycle, no backpressure (no enable/handshake).
// Ports: clk, rst (sync active-high), bus (fa_ha_core_if.slave: a, b, cin -> s, cout[, ovf]).
// Optional feature macro: FA_HA_OVF_EN adds the registered signed-overflow flag ovf.

// Half-adder cell: sum = x ^ y, carry = x & y.
module fa_ha_half_adder (
  input  logic i_x,
  input  logic i_y,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_x ^ i_y;
  assign o_c = i_x & i_y;
endmodule

module fa_ha_core #(
  parameter int WIDTH = 1
) (
  input  logic           clk,
  input  logic           rst,
  fa_ha_core_if.slave    bus
);

  // w_c[i] is the carry into bit i; w_c[0] is the external carry-in.
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_sum;

  logic [WIDTH-1:0] r_s;
  logic             r_cout;

  assign w_c[0] = bus.cin;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      logic w_p;
      logic w_g1;
      logic w_g2;

      // First half adder: propagate/generate from the operand bits.
      fa_ha_half_adder u_ha1 (
        .i_x (bus.a[i]),
        .i_y (bus.b[i]),
        .o_s (w_p),
        .o_c (w_g1)
      );

      // Second half adder folds in the incoming ripple carry.
      fa_ha_half_adder u_ha2 (
        .i_x (w_p),
        .i_y (w_c[i]),
        .o_s (w_sum[i]),
        .o_c (w_g2)
      );

      // Both carries can never be 1 together, so OR is exact.
      assign w_c[i+1] = w_g1 | w_g2;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s    <= '0;
      r_cout <= 1'b0;
    end else begin
      r_s    <= w_sum;
      r_cout <= w_c[WIDTH];
    end
  end

  assign bus.s    = r_s;
  assign bus.cout = r_cout;

`ifdef FA_HA_OVF_EN
  logic r_ovf;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_c[WIDTH] ^ w_c[WIDTH-1];
    end
  end

  assign bus.ovf = r_ovf;
`endif

endmodule

// File: tb/tb_fa_ha_core.sv
module tb_fa_ha_core;

  logic clk;
  logic rst1, rst4, rst8;

  int checks;
  int errors;

  fa_ha_core_if #(.WIDTH(1)) if1 ();
  fa_ha_core_if #(.WIDTH(4)) if4 ();
  fa_ha_core_if #(.WIDTH(8)) if8 ();

  fa_ha_core #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));
  fa_ha_core #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst4), .bus(if4.slave));
  fa_ha_core #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst8), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic a;
    logic b;
    logic cin;
    logic s;
    logic cout;
  } vec1_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] s;
    logic       cout;
    logic       ovf;
  } vec4_t;

  vec1_t t1 [8];
  vec4_t t4 [5];
  vec4_t tb2b [3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] exp8;
    int         sum4;
    logic [4:0] exp4;
    logic       eovf4;

    checks = 0;
    errors = 0;

    // WIDTH=1 exhaustive truth table: (a,b,cin) -> (s,cout)
    t1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    t1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    t1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    t1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    t1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    t1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    t1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    t1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // WIDTH=4 boundary and signed-overflow vectors
    t4[0] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0};
    t4[1] = '{4'h7, 4'h8, 1'b0, 4'hF, 1'b0, 1'b0};
    t4[2] = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1};
    t4[3] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1};
    t4[4] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0};

    // WIDTH=4 back-to-back sequence
    tb2b[0] = '{4'h3, 4'h5, 1'b0, 4'h8, 1'b0, 1'b1};
    tb2b[1] = '{4'h9, 4'h9, 1'b1, 4'h3, 1'b1, 1'b1};
    tb2b[2] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};

    // Reset state, with nonzero operands that must be ignored
    rst1 = 1'b1; rst4 = 1'b1; rst8 = 1'b1;
    if1.a = 1'b1;  if1.b = 1'b1;  if1.cin = 1'b1;
    if4.a = 4'hF;  if4.b = 4'hF;  if4.cin = 1'b1;
    if8.a = 8'hFF; if8.b = 8'hFF; if8.cin = 1'b1;
    tick();
    chk("rst_w4_s", 64'(if4.s), 64'h0);
    chk("rst_w4_cout", 64'(if4.cout), 64'h0);
    chk("rst_w8_s", 64'(if8.s), 64'h0);
    chk("rst_w8_cout", 64'(if8.cout), 64'h0);
`ifdef FA_HA_OVF_EN
    chk("rst_w4_ovf", 64'(if4.ovf), 64'h0);
`endif
    // Second reset edge on WIDTH=1 with a=b=cin=1
    tick();
    chk("rst2_w1_s", 64'(if1.s), 64'h0);
    chk("rst2_w1_cout", 64'(if1.cout), 64'h0);
    rst1 = 1'b0; rst4 = 1'b0; rst8 = 1'b0;
    tick();
    chk("rel_w1_s", 64'(if1.s), 64'h1);
    chk("rel_w1_cout", 64'(if1.cout), 64'h1);

    // WIDTH=1 exhaustive, one combination per cycle
    for (int i = 0; i < 8; i++) begin
      if1.a = t1[i].a; if1.b = t1[i].b; if1.cin = t1[i].cin;
      tick();
      chk($sformatf("w1_s[%0d]", i), 64'(if1.s), 64'(t1[i].s));
      chk($sformatf("w1_cout[%0d]", i), 64'(if1.cout), 64'(t1[i].cout));
    end

    // WIDTH=4 boundary / overflow table
    for (int i = 0; i < 5; i++) begin
      if4.a = t4[i].a; if4.b = t4[i].b; if4.cin = t4[i].cin;
      tick();
      chk($sformatf("w4_s[%0d]", i), 64'(if4.s), 64'(t4[i].s));
      chk($sformatf("w4_cout[%0d]", i), 64'(if4.cout), 64'(t4[i].cout));
`ifdef FA_HA_OVF_EN
      chk($sformatf("w4_ovf[%0d]", i), 64'(if4.ovf), 64'(t4[i].ovf));
`endif
    end

    // WIDTH=4 back-to-back: outputs hold the previous result until the edge
    if4.a = tb2b[0].a; if4.b = tb2b[0].b; if4.cin = tb2b[0].cin;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b_s[%0d]", i), 64'(if4.s), 64'(tb2b[i].s));
      chk($sformatf("b2b_cout[%0d]", i), 64'(if4.cout), 64'(tb2b[i].cout));
      if (i < 2) begin
        if4.a = tb2b[i+1].a; if4.b = tb2b[i+1].b; if4.cin = tb2b[i+1].cin;
        #2;
        chk($sformatf("b2b_hold[%0d]", i), 64'(if4.s), 64'(tb2b[i].s));
        tick();
      end
    end

    // Randomized: WIDTH=8 and WIDTH=4 against arithmetic reference, with reset pulses
    for (int n = 0; n < 1000; n++) begin
      if8.a   = 8'($urandom);
      if8.b   = 8'($urandom);
      if8.cin = 1'($urandom);
      rst8    = ($urandom_range(0, 19) == 0);
      if4.a   = 4'($urandom);
      if4.b   = 4'($urandom);
      if4.cin = 1'($urandom);
      rst4    = ($urandom_range(0, 19) == 0);

      exp8 = rst8 ? 9'h0 : (9'(if8.a) + 9'(if8.b) + 9'(if8.cin));
      sum4 = int'($signed(if4.a)) + int'($signed(if4.b)) + int'(if4.cin);
      exp4 = rst4 ? 5'h0 : (5'(if4.a) + 5'(if4.b) + 5'(if4.cin));
      eovf4 = rst4 ? 1'b0 : ((sum4 > 7) || (sum4 < -8));

      tick();
      chk($sformatf("rnd8[%0d]", n), 64'({if8.cout, if8.s}), 64'(exp8));
      chk($sformatf("rnd4[%0d]", n), 64'({if4.cout, if4.s}), 64'(exp4));
`ifdef FA_HA_OVF_EN
      chk($sformatf("rnd4_ovf[%0d]", n), 64'(if4.ovf), 64'(eovf4));
`else
      if (eovf4 === 1'bx) chk("rnd4_ovf_model", 64'(eovf4), 64'h0);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
